audio_sample_scheduler: RTL
===========================

// Module: audio_sample_scheduler
// PURPOSE
//  Generates the audio sample-rate tick from the system clock. The period is run-time
//  programmable and has a fractional part, so the long-run average rate is exact.
//  On each tick it runs one frame: a valid/ready handshake that issues voice indices
//  0..NUM_VOICES-1 to the downstream voice engine. It flags frames that do not finish
//  before the next tick.
// PARAMETERS
//  CNT_WIDTH      12    width of sample_cycle_count and period_int
//  FRAC_WIDTH     8     width of period_frac and of the fractional accumulator
//  NUM_VOICES     16    voices per frame, >=1; IDX_W = max(1,$clog2(NUM_VOICES))
//  DEFAULT_PERIOD 2272  integer period in effect after reset (fraction resets to 0)
// PORTS
//  clk                in   1           system clock
//  rst_n              in   1           asynchronous reset, active-low
//  enable             in   1           1 = counter runs; 0 = counter/accumulator hold
//  period_int         in   CNT_WIDTH   new integer period (clk cycles)
//  period_frac        in   FRAC_WIDTH  new fractional period, units of 2^-FRAC_WIDTH
//  period_load        in   1           strobe: capture period_int/frac into shadow regs
//  sample_cycle_count out  CNT_WIDTH   position within the current sample period
//  sample_tick        out  1           one-cycle pulse at the start of each sample period
//  voice_idx          out  IDX_W       voice being issued
//  voice_valid        out  1           voice_idx is valid
//  voice_ready        in   1           downstream accepts voice_idx
//  frame_done         out  1           one-cycle pulse after the last voice transfers
//  overrun            out  1           sticky: a tick arrived while a frame was active
//  overrun_clr        in   1           clears overrun
// BEHAVIOUR
//  Reset (async assert, sync release): count=0, frac_acc=0, active/shadow int=DEFAULT_PERIOD,
//   active/shadow frac=0, carry=0, sample_tick=0, voice_valid=0, voice_idx=0,
//   frame_done=0, overrun=0, FSM=IDLE. No state is kept across reset.
//  Period load: period_load captures inputs into shadow registers in that cycle. A
//   period_int below 2 is clamped to 2. Shadow values are copied to active only at a wrap,
//   so the period in progress is never altered. The last load before a wrap wins.
//  Counter (only when enable=1): len = active_int + carry, computed in CNT_WIDTH+1 bits.
//   If count == len-1: count <= 0, {carry,frac_acc} <= frac_acc + frac (using the new
//   active frac), active <= shadow. Otherwise count++.
//   Average period = int + frac/2^FRAC_WIDTH.
//  sample_tick is registered. It is 1 in the cycle after a wrap decision, so it coincides
//   with count==0. There is no tick on the first cycle after reset.
//  enable=0: count, frac_acc and carry hold; no ticks. The voice FSM keeps running.
//  Voice FSM, IDLE -> ISSUE -> DONE -> IDLE:
//   IDLE: on sample_tick, voice_valid<=1, voice_idx<=0, go to ISSUE.
//   ISSUE: a transfer happens when valid && ready. On a transfer with idx<NUM_VOICES-1,
//    idx++. On a transfer with idx==NUM_VOICES-1, valid<=0 and go to DONE.
//    idx and valid stay stable while ready=0.
//   DONE: frame_done=1 for exactly one cycle, voice_idx<=0, go to IDLE.
//  Overrun: sample_tick in ISSUE or DONE sets overrun. That tick is dropped, not queued,
//   and the current frame completes normally. overrun_clr clears overrun. If set and
//   clear occur in the same cycle, set wins.
//  Throughput: with ready held at 1, a frame takes NUM_VOICES+1 cycles after the tick.
//   Frames need period >= NUM_VOICES+2 to avoid overrun.
// TESTING
//  1 Reset, enable=1, no load -> ticks every 2272 cycles; count wraps 2271->0; frac 0.
//  2 Load int=10, frac=128 mid-period -> current period unchanged; later periods
//    alternate 10,11 (avg 10.5); 100 periods take exactly 1050 cycles.
//  3 NUM_VOICES=4, ready=1 -> idx 0,1,2,3 on the 4 cycles after the tick; frame_done
//    pulses the following cycle; valid=0 after that.
//  4 ready=0 for 5 cycles at idx 2 -> idx=2, valid=1 held; then idx 3, frame_done.
//    Period 8 with stalls -> overrun=1 and stays 1; overrun_clr -> 0; set+clr -> 1.
//  5 rst_n low mid-frame -> valid/tick/frame_done drop immediately (no clock); after
//    release, period reverts to 2272, count=0.
//  6 enable=0 for 50 cycles -> count frozen, no tick; load int=1 -> period 2 applied.

Source files
------------

// File: rtl/audio_sample_scheduler.sv
// Audio sample-rate tick generator and per-frame voice issuer.
//
// A programmable fractional-period counter produces a one-cycle sample_tick. Each tick
// starts a frame that hands voice indices 0..NUM_VOICES-1 to the voice engine over a
// valid/ready handshake. A tick that lands while a frame is still running is dropped
// and recorded in the sticky overrun flag.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   enable              1 = period counter runs, 0 = counter and accumulator hold
//   period_int/frac     new period (integer cycles + fraction of 2^-FRAC_WIDTH)
//   period_load         strobe capturing period_int/frac into the shadow registers
//   sample_cycle_count  position within the current sample period
//   sample_tick         one-cycle pulse, coincides with sample_cycle_count == 0
//   voice_idx/valid     voice being issued; voice_ready accepts it
//   frame_done          one-cycle pulse after the last voice transfers
//   overrun/overrun_clr sticky late-frame flag and its clear (set wins over clear)
module audio_sample_scheduler #(
    parameter int unsigned CNT_WIDTH      = 12,
    parameter int unsigned FRAC_WIDTH     = 8,
    parameter int unsigned NUM_VOICES     = 16,
    parameter int unsigned DEFAULT_PERIOD = 2272
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [CNT_WIDTH-1:0]  period_int,
    input  logic [FRAC_WIDTH-1:0] period_frac,
    input  logic                  period_load,
    output logic [CNT_WIDTH-1:0]  sample_cycle_count,
    output logic                  sample_tick,
    output logic [((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1)-1:0] voice_idx,
    output logic                  voice_valid,
    input  logic                  voice_ready,
    output logic                  frame_done,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IdxW-1:0]      LastIdx   = IdxW'(NUM_VOICES - 1);
    localparam logic [CNT_WIDTH-1:0] DefPeriod = CNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] MinPeriod = CNT_WIDTH'(2);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    // Period counter state
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [FRAC_WIDTH-1:0] frac_acc_q, frac_acc_d;
    logic                  carry_q, carry_d;
    logic [CNT_WIDTH-1:0]  act_int_q, act_int_d, sh_int_q, sh_int_d;
    logic [FRAC_WIDTH-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
    logic                  tick_q, tick_d;

    // Voice FSM state
    state_e          state_q, state_d;
    logic            valid_q, valid_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            overrun_q, overrun_d;

    logic [CNT_WIDTH:0]  len, len_m1;
    logic [FRAC_WIDTH:0] frac_sum;
    logic                wrap;
    logic                xfer;

    // The carry from the previous wrap stretches this period by one cycle.
    assign len      = {1'b0, act_int_q} + {{CNT_WIDTH{1'b0}}, carry_q};
    assign len_m1   = len - (CNT_WIDTH + 1)'(1);
    assign wrap     = enable && ({1'b0, count_q} == len_m1);
    // The fraction accumulated at a wrap is the one about to become active.
    assign frac_sum = {1'b0, frac_acc_q} + {1'b0, sh_frac_q};
    assign xfer     = valid_q && voice_ready;

    always_comb begin
        count_d    = count_q;
        frac_acc_d = frac_acc_q;
        carry_d    = carry_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        tick_d     = wrap;

        if (period_load) begin
            sh_int_d  = (period_int < MinPeriod) ? MinPeriod : period_int;
            sh_frac_d = period_frac;
        end

        if (wrap) begin
            count_d    = '0;
            frac_acc_d = frac_sum[FRAC_WIDTH-1:0];
            carry_d    = frac_sum[FRAC_WIDTH];
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
        end else if (enable) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            frac_acc_q <= '0;
            carry_q    <= 1'b0;
            act_int_q  <= DefPeriod;
            act_frac_q <= '0;
            sh_int_q   <= DefPeriod;
            sh_frac_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            frac_acc_q <= frac_acc_d;
            carry_q    <= carry_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            tick_q     <= tick_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (tick_q) begin
                    valid_d = 1'b1;
                    idx_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (xfer) begin
                    if (idx_q == LastIdx) begin
                        valid_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StDone: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A tick during an active frame is dropped; only the flag records it.
        if (tick_q && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // FSM outputs
    always_comb begin
        frame_done         = (state_q == StDone);
        voice_valid        = valid_q;
        voice_idx          = idx_q;
        sample_tick        = tick_q;
        sample_cycle_count = count_q;
        overrun            = overrun_q;
    end

endmodule
